// File: rtl/execute_mem_stage_skid_pkg.sv
// rtl/execute_mem_stage_skid_pkg.sv - shared execute-mem widths and skid-stage types
package execute_mem_stage_skid_pkg;

  // Default tag and address widths, shared by the S1/S3 execute-mem stages.
  localparam int EM_ROB_W  = 4;
  localparam int EM_FID_W  = 8;
  localparam int EM_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // Packed payload: tags, three access flags, two addresses, uncached flag.
  function automatic int payload_w(input int rob_w, input int fid_w, input int addr_w);
    return rob_w + fid_w + 3 + 2 * addr_w + 1;
  endfunction

endpackage

// File: rtl/execute_mem_stage_skid_slot.sv
// rtl/execute_mem_stage_skid_slot.sv - one skid-buffer slot: valid bit plus enabled payload register
module execute_mem_skid_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic         valid_next,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!resetn) valid <= 1'b0;
    else         valid <= valid_next;
  end

  // Payload is deliberately unreset; it is only meaningful while valid is set.
  always_ff @(posedge clk) begin
    if (load) q <= d;
  end

endmodule

// File: rtl/execute_mem_stage_skid.sv
// rtl/execute_mem_stage_skid.sv - execute-mem pipeline stage with a two-slot skid buffer
module execute_mem_stage_skid
  import execute_mem_stage_skid_pkg::*;
#(
  parameter int ROB_W  = EM_ROB_W,
  parameter int FID_W  = EM_FID_W,
  parameter int ADDR_W = EM_ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ROB_W-1:0]  i_dst_rob,
  input  logic [FID_W-1:0]  i_fid,
  input  logic              i_s_byte,
  input  logic              i_s_store,
  input  logic              i_s_load,
  input  logic [ADDR_W-1:0] i_agu_v_addr,
  input  logic [ADDR_W-1:0] i_agu_p_addr,
  input  logic              i_agu_p_uncached,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ROB_W-1:0]  o_dst_rob,
  output logic [FID_W-1:0]  o_fid,
  output logic              o_s_byte,
  output logic              o_s_store,
  output logic              o_s_load,
  output logic [ADDR_W-1:0] o_agu_v_addr,
  output logic [ADDR_W-1:0] o_agu_p_addr,
  output logic              o_agu_p_uncached
);

  localparam int PW = payload_w(ROB_W, FID_W, ADDR_W);

  logic [PW-1:0] in_payload;
  logic [PW-1:0] main_d;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  logic          main_valid;
  logic          skid_valid;
  logic          main_valid_next;
  logic          skid_valid_next;
  logic          main_load;
  logic          skid_load;
  logic          main_from_skid;
  logic          accept;
  logic          send;
  skid_state_e   state;

  assign in_payload = {i_dst_rob, i_fid, i_s_byte, i_s_store, i_s_load,
                       i_agu_v_addr, i_agu_p_addr, i_agu_p_uncached};

  // o_ready comes straight from the SKID valid flop, never from i_ready.
  assign o_ready = ~skid_valid;
  assign o_valid = main_valid;
  assign accept  = i_valid & o_ready;
  assign send    = o_valid & i_ready;

  always_comb begin
    if (skid_valid)      state = ST_FULL;
    else if (main_valid) state = ST_ONE;
    else                 state = ST_EMPTY;
  end

  always_comb begin
    main_valid_next = main_valid;
    skid_valid_next = skid_valid;
    main_load       = 1'b0;
    skid_load       = 1'b0;
    main_from_skid  = 1'b0;
    if (i_flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_load       = 1'b1;
            main_valid_next = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && send) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load       = 1'b1;
            skid_valid_next = 1'b1;
          end else if (send) begin
            main_valid_next = 1'b0;
          end
        end
        ST_FULL: begin
          // Input is blocked here, so the only move is draining SKID into MAIN.
          if (send) begin
            main_load       = 1'b1;
            main_from_skid  = 1'b1;
            skid_valid_next = 1'b0;
          end
        end
        default: begin
          main_valid_next = 1'b0;
          skid_valid_next = 1'b0;
        end
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_payload;

  execute_mem_skid_slot #(.W(PW)) u_main (
    .clk        (clk),
    .resetn     (resetn),
    .load       (main_load),
    .valid_next (main_valid_next),
    .d          (main_d),
    .valid      (main_valid),
    .q          (main_q)
  );

  execute_mem_skid_slot #(.W(PW)) u_skid (
    .clk        (clk),
    .resetn     (resetn),
    .load       (skid_load),
    .valid_next (skid_valid_next),
    .d          (in_payload),
    .valid      (skid_valid),
    .q          (skid_q)
  );

  assign {o_dst_rob, o_fid, o_s_byte, o_s_store, o_s_load,
          o_agu_v_addr, o_agu_p_addr, o_agu_p_uncached} = main_q;

endmodule

// File: tb/tb_execute_mem_stage_skid.sv
// tb/tb_execute_mem_stage_skid.sv - self-checking bench for execute_mem_stage_skid
module tb_execute_mem_stage_skid;

  localparam int RW = 6;
  localparam int FW = 8;
  localparam int AW = 40;

  logic          clk = 1'b0;
  logic          resetn;
  logic          i_flush;
  logic          i_valid;
  logic          o_ready;
  logic [RW-1:0] i_dst_rob;
  logic [FW-1:0] i_fid;
  logic          i_s_byte, i_s_store, i_s_load;
  logic [AW-1:0] i_agu_v_addr, i_agu_p_addr;
  logic          i_agu_p_uncached;
  logic          o_valid;
  logic          i_ready;
  logic [RW-1:0] o_dst_rob;
  logic [FW-1:0] o_fid;
  logic          o_s_byte, o_s_store, o_s_load;
  logic [AW-1:0] o_agu_v_addr, o_agu_p_addr;
  logic          o_agu_p_uncached;

  always #5 clk = ~clk;

  execute_mem_stage_skid #(.ROB_W(RW), .FID_W(FW), .ADDR_W(AW)) u_dut (
    .clk              (clk),
    .resetn           (resetn),
    .i_flush          (i_flush),
    .i_valid          (i_valid),
    .o_ready          (o_ready),
    .i_dst_rob        (i_dst_rob),
    .i_fid            (i_fid),
    .i_s_byte         (i_s_byte),
    .i_s_store        (i_s_store),
    .i_s_load         (i_s_load),
    .i_agu_v_addr     (i_agu_v_addr),
    .i_agu_p_addr     (i_agu_p_addr),
    .i_agu_p_uncached (i_agu_p_uncached),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_dst_rob        (o_dst_rob),
    .o_fid            (o_fid),
    .o_s_byte         (o_s_byte),
    .o_s_store        (o_s_store),
    .o_s_load         (o_s_load),
    .o_agu_v_addr     (o_agu_v_addr),
    .o_agu_p_addr     (o_agu_p_addr),
    .o_agu_p_uncached (o_agu_p_uncached)
  );

  typedef struct packed {
    logic [RW-1:0] rob;
    logic [FW-1:0] fid;
    logic          b, s, l;
    logic [AW-1:0] va, pa;
    logic          unc;
  } ent_t;

  ent_t in_ent, dut_ent, held_ent;
  ent_t mq[$];
  bit   armed = 0;
  bit   held  = 0;
  int   total = 0;
  int   bad   = 0;
  int   n_acc = 0;
  int   n_sent = 0;

  assign in_ent  = {i_dst_rob, i_fid, i_s_byte, i_s_store, i_s_load,
                    i_agu_v_addr, i_agu_p_addr, i_agu_p_uncached};
  assign dut_ent = {o_dst_rob, o_fid, o_s_byte, o_s_store, o_s_load,
                    o_agu_v_addr, o_agu_p_addr, o_agu_p_uncached};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: an in-order queue of capacity two, head is what the outputs show.
  always @(posedge clk) begin
    bit snd, acc;
    if (!resetn || i_flush) begin
      mq.delete();
      if (!resetn) armed = 1;
    end else begin
      snd = (mq.size() > 0) && i_ready;
      acc = i_valid && (mq.size() < 2);
      if (snd) void'(mq.pop_front());
      if (acc) mq.push_back(in_ent);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("o_valid", o_valid, mq.size() > 0);
      chk("o_ready", o_ready, mq.size() < 2);
      if (mq.size() > 0) chk("payload", dut_ent, mq[0]);
      if (held) chk("stall_hold", {o_valid, dut_ent}, {1'b1, held_ent});
      held     = o_valid && !i_ready && resetn && !i_flush;
      held_ent = dut_ent;
      if (resetn && !i_flush) begin
        if (i_valid && o_ready) n_acc++;
        if (o_valid && i_ready) n_sent++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [7:0] f);
    i_valid          = v;
    i_fid            = f;
    i_dst_rob        = RW'($urandom);
    i_s_byte         = 1'($urandom);
    i_s_store        = 1'($urandom);
    i_s_load         = 1'($urandom);
    i_agu_v_addr     = {8'($urandom), $urandom};
    i_agu_p_addr     = {8'($urandom), $urandom};
    i_agu_p_uncached = 1'($urandom);
  endtask

  initial begin
    resetn  = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b0;
    set_in(0, 8'h00);
    cyc();
    cyc();
    chk("reset_valid", o_valid, 1'b0);
    chk("reset_ready", o_ready, 1'b1);
    resetn = 1'b1;

    // Streaming: one-cycle latency, o_ready never drops.
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_in(1, 8'(k));
      cyc();
      chk("stream_fid", o_fid, k);
      chk("stream_valid", o_valid, 1'b1);
      chk("stream_ready", o_ready, 1'b1);
    end
    set_in(0, 8'h00);
    cyc();
    chk("stream_drain", o_valid, 1'b0);

    // Stall into FULL, then release.
    i_ready = 1'b0;
    set_in(1, 8'h10);
    cyc();
    chk("stall_first", o_fid, 8'h10);
    set_in(1, 8'h11);
    cyc();
    chk("stall_full_ready", o_ready, 1'b0);
    chk("stall_full_fid", o_fid, 8'h10);
    set_in(0, 8'h00);
    cyc();
    chk("stall_still_fid", o_fid, 8'h10);
    i_ready = 1'b1;
    cyc();
    chk("release_fid", o_fid, 8'h11);
    chk("release_ready", o_ready, 1'b1);
    cyc();
    chk("release_empty", o_valid, 1'b0);

    // Flush while FULL with a same-cycle input.
    i_ready = 1'b0;
    set_in(1, 8'h20);
    cyc();
    set_in(1, 8'h21);
    cyc();
    chk("flush_pre_ready", o_ready, 1'b0);
    set_in(1, 8'h22);
    i_flush = 1'b1;
    cyc();
    chk("flush_valid", o_valid, 1'b0);
    chk("flush_ready", o_ready, 1'b1);
    i_flush = 1'b0;
    set_in(0, 8'h00);
    i_ready = 1'b1;
    cyc();
    cyc();
    chk("flush_no_ghost", o_valid, 1'b0);

    // Reset while FULL.
    i_ready = 1'b0;
    set_in(1, 8'h30);
    cyc();
    set_in(1, 8'h31);
    cyc();
    chk("rst_pre_ready", o_ready, 1'b0);
    set_in(0, 8'h00);
    resetn = 1'b0;
    cyc();
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    resetn  = 1'b1;
    i_ready = 1'b1;
    cyc();
    cyc();
    chk("rst_no_stale", o_valid, 1'b0);

    // Wide parameters pass through intact.
    i_ready = 1'b0;
    set_in(1, 8'h40);
    i_dst_rob    = 6'h2A;
    i_agu_p_addr = 40'hFF_1234_5678;
    cyc();
    chk("wide_paddr", o_agu_p_addr, 40'hFF_1234_5678);
    chk("wide_rob", o_dst_rob, 6'h2A);
    set_in(0, 8'h00);
    i_ready = 1'b1;
    cyc();
    cyc();

    // Random handshakes over 1000 accepted entries.
    n_acc  = 0;
    n_sent = 0;
    for (int c = 0; c < 20000 && n_acc < 1000; c++) begin
      set_in(1'($urandom_range(0, 1)), 8'(c));
      i_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    set_in(0, 8'h00);
    i_ready = 1'b1;
    repeat (4) cyc();
    chk("rand_budget", n_acc >= 1000, 1'b1);
    chk("rand_lossless", n_sent, n_acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute_mem_stage_skid.md
EXECUTE_MEM_STAGE_SKID -- requirements
Module: execute_mem_stage_skid

Interface
REQ-001 Parameter ROB_W, default 4: destination ROB index width.
REQ-002 Parameter FID_W, default 8: fetch ID width.
REQ-003 Parameter ADDR_W, default 32: virtual and physical address width.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 resetn  input  1  reset; synchronous, active-low.
REQ-006 i_flush  input  1  pipeline flush; discards all held and incoming entries.
REQ-007 i_valid  input  1  upstream entry valid.
REQ-008 o_ready  output  1  stage can accept an entry this cycle.
REQ-009 i_dst_rob / i_fid  input  ROB_W / FID_W  entry tags.
REQ-010 i_s_byte, i_s_store, i_s_load  input  1 each  access-type flags.
REQ-011 i_agu_v_addr / i_agu_p_addr  input  ADDR_W each  virtual / physical address.
REQ-012 i_agu_p_uncached  input  1  physical address is uncached.
REQ-013 o_valid  output  1  downstream entry valid.
REQ-014 i_ready  input  1  downstream accepts an entry this cycle.
REQ-015 o_dst_rob, o_fid, o_s_byte, o_s_store, o_s_load, o_agu_v_addr, o_agu_p_addr, o_agu_p_uncached  output  same widths as the inputs  registered payload.

Function
REQ-016 Accept SHALL occur when i_valid & o_ready; send SHALL occur when o_valid & i_ready.
REQ-017 The stage SHALL hold two slots, MAIN (drives the outputs) and SKID, giving states EMPTY, ONE (MAIN only) and FULL (MAIN and SKID).
REQ-018 o_ready SHALL equal ~SKID.valid, driven from a register with no combinational path from i_ready.
REQ-019 EMPTY + accept SHALL load MAIN and go to ONE; latency input to o_valid = 1 cycle.
REQ-020 ONE + accept + send SHALL load MAIN with the input and stay in ONE.
REQ-021 ONE + accept + no send SHALL load SKID and go to FULL.
REQ-022 ONE + send + no accept SHALL go to EMPTY.
REQ-023 FULL + send SHALL move SKID into MAIN and go to ONE; no accept is possible in FULL.
REQ-024 While o_valid & ~i_ready, all o_* payload outputs SHALL be held stable.
REQ-025 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or dropped except by flush or reset.
REQ-026 i_flush SHALL clear both slot valids at the next edge, discard any same-cycle input, and have priority over accept and send.
REQ-027 After a flush, the stage SHALL be EMPTY with o_ready = 1 in the next cycle.
REQ-028 Payload registers SHALL load only on slot fill and SHALL NOT be qualified by valid for output.

Reset
REQ-029 resetn low at an edge SHALL force EMPTY: o_valid = 0, o_ready = 1, SKID.valid = 0.
REQ-030 Payload registers SHALL NOT be reset; o_* payload values are don't-care while o_valid = 0.
REQ-031 Reset during FULL or mid-transfer SHALL discard both entries with no output pulse afterward.
REQ-032 Reset SHALL have priority over i_flush and all handshakes.

Structure
REQ-033 Default widths (ROB_W = 4, FID_W = 8, ADDR_W = 32) SHALL live in the shared execute-mem constants header, reused by the S1/S3 stages.
REQ-034 One sub-module, execute_mem_skid_slot (valid bit plus payload register with a load enable), SHALL be instantiated twice, as MAIN and SKID.

Verification
REQ-035 Streaming: i_ready = 1, 8 back-to-back entries with fid 0..7 -> o_fid 0..7 on consecutive cycles, each 1 cycle after input; o_ready stays 1.
REQ-036 Stall: i_ready = 0, entries fid 0x10, 0x11 -> FULL, o_ready = 0, o_fid held at 0x10; i_ready = 1 -> o_fid 0x10 then 0x11, o_ready returns to 1.
REQ-037 Flush in FULL with i_valid = 1 (fid 0x22) -> next cycle o_valid = 0, o_ready = 1; fid 0x22 never appears at the output.
REQ-038 Reset in FULL: resetn low 1 cycle -> o_valid = 0, o_ready = 1; no stale entry is emitted after release.
REQ-039 Parameters ROB_W = 6, ADDR_W = 40: o_agu_p_addr = 0xFF_1234_5678 and o_dst_rob = 0x2A pass through intact.
REQ-040 Randomised i_valid/i_ready, 1000 entries -> scoreboard shows in-order, lossless, payload stable under stall.
